trap_controller: RTL

Machine-mode trap sequencer for the RV32 core. It watches exception flags from decode/LSU, pending-interrupt lines and `mret`. It then produces the cause-capture strobe, cause code and interrupt/exception flag consumed by the `mcause` CSR, plus the `mepc` capture, `mstatus.MIE` update, PC-source select and pipeline flush. It sits between the pipeline and the CSR file and is the sole writer of trap causes.

---
 rtl/trap_controller_if.sv | 51 +++++
 rtl/trap_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/trap_controller_if.sv
// Trap controller bus: pipeline event flags in, CSR/PC/flush controls out.
// The pipeline side uses the master modport; the trap controller uses slave.
interface trap_controller_if;
    // Exception and event flags from decode/LSU
    logic       instr_misaligned_in;
    logic       illegal_instr_in;
    logic       ecall_in;
    logic       ebreak_in;
    logic       load_misaligned_in;
    logic       store_misaligned_in;
    logic       mret_in;

    // Interrupt enables and pending lines
    logic       mie_in;
    logic       meie_in;
    logic       msie_in;
    logic       mtie_in;
    logic       e_irq_in;
    logic       s_irq_in;
    logic       t_irq_in;

    // Controls towards the CSR file, PC mux and pipeline
    logic       set_cause_out;
    logic [3:0] cause_out;
    logic       i_or_e_out;
    logic       set_epc_out;
    logic       mie_clear_out;
    logic       mie_set_out;
    logic [1:0] pc_src_out;
    logic       flush_out;
    logic       instret_inc_out;
    logic       trap_taken_out;

    modport master (
        output instr_misaligned_in, illegal_instr_in, ecall_in, ebreak_in,
               load_misaligned_in, store_misaligned_in, mret_in,
               mie_in, meie_in, msie_in, mtie_in, e_irq_in, s_irq_in, t_irq_in,
        input  set_cause_out, cause_out, i_or_e_out, set_epc_out,
               mie_clear_out, mie_set_out, pc_src_out, flush_out,
               instret_inc_out, trap_taken_out
    );

    modport slave (
        input  instr_misaligned_in, illegal_instr_in, ecall_in, ebreak_in,
               load_misaligned_in, store_misaligned_in, mret_in,
               mie_in, meie_in, msie_in, mtie_in, e_irq_in, s_irq_in, t_irq_in,
        output set_cause_out, cause_out, i_or_e_out, set_epc_out,
               mie_clear_out, mie_set_out, pc_src_out, flush_out,
               instret_inc_out, trap_taken_out
    );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer for the RV32 core.
// Decides between exception entry, interrupt entry, mret and normal retirement,
// and drives the mcause/mepc/mstatus strobes, PC select and pipeline flush.
// Optional feature macro: TRAP_CTRL_IRQ_EN enables the interrupt path; without
// it the interrupt inputs are ignored and only exceptions and mret act.
module trap_controller (
    input  logic              clk_in,
    input  logic              rst_in,
    trap_controller_if.slave  bus
);

    localparam logic [1:0] BOOT_SEL = 2'b00;
    localparam logic [1:0] EPC_SEL  = 2'b01;
    localparam logic [1:0] TRAP_SEL = 2'b10;
    localparam logic [1:0] NEXT_SEL = 2'b11;

    typedef enum logic [1:0] {
        RESET       = 2'd0,
        OPERATING   = 2'd1,
        TRAP_TAKEN  = 2'd2,
        TRAP_RETURN = 2'd3
    } state_t;

    state_t     state;
    logic       trap_taken_q;

    logic       exc_any;
    logic [3:0] exc_cause;
    logic       irq_any;
    logic [3:0] irq_cause;
    logic       take_trap;
    logic       take_mret;

    logic       set_cause;
    logic [3:0] cause;
    logic       i_or_e;
    logic       set_epc;
    logic       mie_clear;
    logic       mie_set;
    logic [1:0] pc_src;
    logic       flush;
    logic       instret_inc;

    // Pick the highest-priority synchronous exception and its cause code
    always_comb begin
        exc_any   = 1'b1;
        exc_cause = 4'd0;
        if (bus.instr_misaligned_in)      exc_cause = 4'd0;
        else if (bus.illegal_instr_in)    exc_cause = 4'd2;
        else if (bus.ecall_in)            exc_cause = 4'd11;
        else if (bus.ebreak_in)           exc_cause = 4'd3;
        else if (bus.load_misaligned_in)  exc_cause = 4'd4;
        else if (bus.store_misaligned_in) exc_cause = 4'd6;
        else                              exc_any   = 1'b0;
    end

`ifdef TRAP_CTRL_IRQ_EN
    // Pick the highest-priority enabled pending interrupt, gated by global MIE
    always_comb begin
        irq_any   = bus.mie_in;
        irq_cause = 4'd0;
        if (bus.meie_in && bus.e_irq_in)      irq_cause = 4'd11;
        else if (bus.msie_in && bus.s_irq_in) irq_cause = 4'd3;
        else if (bus.mtie_in && bus.t_irq_in) irq_cause = 4'd7;
        else                                  irq_any   = 1'b0;
    end
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{bus.mie_in, bus.meie_in, bus.msie_in, bus.mtie_in,
                                 bus.e_irq_in, bus.s_irq_in, bus.t_irq_in};
    assign irq_any   = 1'b0;
    assign irq_cause = 4'd0;
`endif

    assign take_trap = exc_any | irq_any;
    assign take_mret = bus.mret_in & ~take_trap;

    // Mealy output decode from the current state and this cycle's events
    always_comb begin
        set_cause   = 1'b0;
        cause       = 4'd0;
        i_or_e      = 1'b0;
        set_epc     = 1'b0;
        mie_clear   = 1'b0;
        mie_set     = 1'b0;
        pc_src      = NEXT_SEL;
        flush       = 1'b0;
        instret_inc = 1'b0;
        if (rst_in) begin
            pc_src = BOOT_SEL;
            flush  = 1'b1;
        end else begin
            case (state)
                RESET: begin
                    pc_src = BOOT_SEL;
                    flush  = 1'b1;
                end
                OPERATING: begin
                    if (exc_any) begin
                        set_cause = 1'b1;
                        cause     = exc_cause;
                        set_epc   = 1'b1;
                        mie_clear = 1'b1;
                        flush     = 1'b1;
                        pc_src    = TRAP_SEL;
                    end else if (irq_any) begin
                        set_cause = 1'b1;
                        cause     = irq_cause;
                        i_or_e    = 1'b1;
                        set_epc   = 1'b1;
                        mie_clear = 1'b1;
                        flush     = 1'b1;
                        pc_src    = TRAP_SEL;
                    end else if (take_mret) begin
                        mie_set     = 1'b1;
                        flush       = 1'b1;
                        pc_src      = EPC_SEL;
                        instret_inc = 1'b1;
                    end else begin
                        instret_inc = 1'b1;
                    end
                end
                TRAP_TAKEN, TRAP_RETURN: begin
                    flush = 1'b1;
                end
                default: begin
                    pc_src = BOOT_SEL;
                    flush  = 1'b1;
                end
            endcase
        end
    end

    // State register and the registered trap-entry indicator
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= RESET;
            trap_taken_q <= 1'b0;
        end else begin
            trap_taken_q <= 1'b0;
            case (state)
                RESET: state <= OPERATING;
                OPERATING: begin
                    if (take_trap) begin
                        state        <= TRAP_TAKEN;
                        trap_taken_q <= 1'b1;
                    end else if (take_mret) begin
                        state <= TRAP_RETURN;
                    end
                end
                TRAP_TAKEN:  state <= OPERATING;
                TRAP_RETURN: state <= OPERATING;
                default:     state <= RESET;
            endcase
        end
    end

    assign bus.set_cause_out   = set_cause;
    assign bus.cause_out       = cause;
    assign bus.i_or_e_out      = i_or_e;
    assign bus.set_epc_out     = set_epc;
    assign bus.mie_clear_out   = mie_clear;
    assign bus.mie_set_out     = mie_set;
    assign bus.pc_src_out      = pc_src;
    assign bus.flush_out       = flush;
    assign bus.instret_inc_out = instret_inc;
    assign bus.trap_taken_out  = trap_taken_q;

endmodule
